// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package instr_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    FETCH         = 2'd1,
    REDIRECT_WAIT = 2'd2
  } pf_state_e;

  localparam int unsigned BYTE_BITS = 8;

  // Address increment per fetched instruction word, in bytes.
  function automatic int unsigned addr_inc(input int unsigned data_width);
    return data_width / BYTE_BITS;
  endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Power-of-two circular FIFO holding {instruction word, bus error} entries.
module instr_prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    rdata   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: credit-limited bus fetcher feeding a FIFO, with branch/hwloop redirect.
// Optional PREFETCH_BYPASS_EN forwards a response straight to the consumer when the FIFO is empty.
module instr_prefetch_queue
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  hwlp_jump_i,
  input  logic [ADDR_WIDTH-1:0] hwlp_target_i,
  input  logic                  fetch_ready_i,
  output logic                  fetch_valid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  output logic                  fetch_err_o,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  input  logic                  instr_err_i,
  output logic                  busy_o
);

  localparam int unsigned ADDR_INC = addr_inc(DATA_WIDTH);
  localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(ADDR_INC);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(ADDR_INC - 1);

  pf_state_e             state_q;
  logic [OUT_W-1:0]      outstanding_q;
  logic [OUT_W-1:0]      outstanding_n;
  logic [OUT_W-1:0]      discard_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic                  hold_q;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  issue;
  logic                  granted;
  logic                  stalled;
  logic                  rsp_valid;
  logic                  rsp_keep;
  logic                  bypass;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [DATA_WIDTH:0]   head;

  instr_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (fifo_push),
    .wdata ({instr_rdata_i, instr_err_i}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    redirect        = branch_i | hwlp_jump_i;
    redirect_target = (branch_i ? branch_addr_i : hwlp_target_i) & ALIGN_MASK;

    issue = (state_q == FETCH) && req_i
         && ((32'(outstanding_q) + 32'(fifo_count)) < DEPTH)
         && (32'(outstanding_q) < MAX_OUTSTANDING);

    // A request left ungranted is re-presented unchanged regardless of credits or req_i.
    instr_req_o  = hold_q | issue;
    instr_addr_o = (state_q == REDIRECT_WAIT) ? hold_addr_q : next_addr_q;
    granted      = instr_req_o & instr_gnt_i;
    stalled      = instr_req_o & ~instr_gnt_i;

    // Responses with nothing outstanding belong to a transaction abandoned by reset.
    rsp_valid     = instr_rvalid_i & (outstanding_q != '0);
    rsp_keep      = rsp_valid & (discard_q == '0) & ~redirect;
    outstanding_n = outstanding_q + OUT_W'(granted) - OUT_W'(rsp_valid);

    busy_o = (outstanding_q != '0) || (state_q == REDIRECT_WAIT);
  end

`ifdef PREFETCH_BYPASS_EN
  always_comb bypass = rsp_keep & fifo_empty & fetch_ready_i;
`else
  always_comb bypass = 1'b0;
`endif

  always_comb begin
    fifo_push     = rsp_keep & ~bypass;
    fifo_pop      = ~fifo_empty & fetch_ready_i;
    fetch_valid_o = ~fifo_empty | bypass;
    if (bypass)           head = {instr_rdata_i, instr_err_i};
    else if (!fifo_empty) head = fifo_rdata;
    else                  head = '0;
    fetch_rdata_o = head[DATA_WIDTH:1];
    fetch_err_o   = head[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      discard_q     <= '0;
      next_addr_q   <= '0;
      hold_addr_q   <= '0;
      hold_q        <= 1'b0;
    end else begin
      outstanding_q <= outstanding_n;
      hold_q        <= stalled;
      if (stalled) hold_addr_q <= instr_addr_o;

      // The stalled old-address request granted in REDIRECT_WAIT joins the discard set.
      if (redirect)
        discard_q <= outstanding_n;
      else
        discard_q <= discard_q
                   - OUT_W'(rsp_valid && (discard_q != '0))
                   + OUT_W'(granted && (state_q == REDIRECT_WAIT));

      if (redirect)
        next_addr_q <= redirect_target;
      else if (granted && (state_q == FETCH))
        next_addr_q <= next_addr_q + ADDR_STEP;

      case (state_q)
        IDLE: begin
          if (req_i) state_q <= FETCH;
        end
        FETCH: begin
          if (redirect && stalled)   state_q <= REDIRECT_WAIT;
          else if (!req_i && !stalled) state_q <= IDLE;
        end
        REDIRECT_WAIT: begin
          if (instr_gnt_i) state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: directed scenarios, bus/consumer monitor checks grants and deliveries.
module tb_instr_prefetch_queue;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_i = 1'b0;
  logic          branch_i = 1'b0;
  logic [AW-1:0] branch_addr_i = '0;
  logic          hwlp_jump_i = 1'b0;
  logic [AW-1:0] hwlp_target_i = '0;
  logic          fetch_ready_i = 1'b0;
  logic          fetch_valid_o;
  logic [DW-1:0] fetch_rdata_o;
  logic          fetch_err_o;
  logic          instr_req_o;
  logic [AW-1:0] instr_addr_o;
  logic          instr_gnt_i;
  logic          instr_rvalid_i;
  logic [DW-1:0] instr_rdata_i;
  logic          instr_err_i;
  logic          busy_o;

  instr_prefetch_queue #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .hwlp_jump_i    (hwlp_jump_i),
    .hwlp_target_i  (hwlp_target_i),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_err_o    (fetch_err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  initial forever #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail = 0;
  int            gnt_budget = 0;
  int            gnt_count = 0;
  bit            rsp_en = 1'b0;
  logic [AW-1:0] err_addr = '1;
  logic [AW-1:0] exp_addr[$];
  logic [DW:0]   exp_data[$];
  logic [AW-1:0] bus_q[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [DW:0] mem_entry(input logic [AW-1:0] a);
    return {mem_word(a), (a == err_addr)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus slave and consumer monitor: drive at negedge, sample 1 time unit later.
  initial begin
    logic [AW-1:0] a;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_en && bus_q.size() > 0) begin
        a = bus_q.pop_front();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(a);
        instr_err_i    = (a == err_addr);
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
      end
      instr_gnt_i = (gnt_budget > 0) && instr_req_o;
      #1;
      if (instr_req_o && instr_gnt_i) begin
        gnt_budget--;
        gnt_count++;
        bus_q.push_back(instr_addr_o);
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant_addr: unexpected grant at 0x%0h, none required", instr_addr_o);
        end else begin
          check("grant_addr", instr_addr_o, exp_addr.pop_front());
        end
      end
      if (fetch_valid_o && fetch_ready_i) begin
        if (exp_data.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_data: unexpected delivery 0x%0h err %0b, none required",
                   fetch_rdata_o, fetch_err_o);
        end else begin
          check("fetch_data", {fetch_rdata_o, fetch_err_o}, exp_data.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit clear_bus);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_i = 1'b0;
    branch_i = 1'b0;
    hwlp_jump_i = 1'b0;
    fetch_ready_i = 1'b0;
    gnt_budget = 0;
    rsp_en = 1'b0;
    if (clear_bus) bus_q.delete();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string name);
    int i = 0;
    while ((exp_addr.size() != 0 || exp_data.size() != 0) && i < limit) begin
      tick(1);
      i++;
    end
    check(name, 64'(exp_addr.size() + exp_data.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, fetch_valid_o, 0);
    check({tag, "_rdata"}, fetch_rdata_o, 0);
    check({tag, "_err"},   fetch_err_o, 0);
    check({tag, "_req"},   instr_req_o, 0);
    check({tag, "_addr"},  instr_addr_o, 0);
    check({tag, "_busy"},  busy_o, 0);
  endtask

  initial begin
    #100000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    // Reset state
    tick(2);
    check_all_zero("rst");
    rst = 1'b0;
    tick(2);
    check_all_zero("post_rst");

    // Streaming
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    exp_data.push_back(mem_entry(32'h0));
    exp_data.push_back(mem_entry(32'h4));
    exp_data.push_back(mem_entry(32'h8));
    req_i = 1'b1; fetch_ready_i = 1'b1; rsp_en = 1'b1; gnt_budget = 3;
    wait_drain(30, "stream_drain");

    // Backpressure: four grants fill the queue, issue resumes after pops
    do_reset(1'b1);
    gnt_count = 0;
    for (int i = 0; i < 10; i++) begin
      exp_addr.push_back(AW'(4 * i));
      exp_data.push_back(mem_entry(AW'(4 * i)));
    end
    req_i = 1'b1; fetch_ready_i = 1'b0; rsp_en = 1'b1; gnt_budget = 10;
    tick(12);
    check("bp_grants", 64'(gnt_count), 4);
    check("bp_req_low", instr_req_o, 0);
    check("bp_head_valid", fetch_valid_o, 1);
    fetch_ready_i = 1'b1;
    wait_drain(60, "bp_drain");

    // Branch with two responses outstanding
    do_reset(1'b1);
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    req_i = 1'b1; fetch_ready_i = 1'b1; rsp_en = 1'b0; gnt_budget = 2;
    tick(6);
    check("br_busy", busy_o, 1);
    check("br_credit_block", instr_req_o, 0);
    branch_i = 1'b1; branch_addr_i = 32'h103;
    tick(1);
    branch_i = 1'b0;
    rsp_en = 1'b1;
    tick(5);
    check("br_fifo_empty", fetch_valid_o, 0);
    check("br_req", instr_req_o, 1);
    check("br_addr", instr_addr_o, 32'h100);
    check("br_idle_busy", busy_o, 0);
    exp_addr.push_back(32'h100);
    exp_data.push_back(mem_entry(32'h100));
    gnt_budget = 1;
    wait_drain(20, "br_drain");

    // Branch while a request at 0x8 waits for grant
    do_reset(1'b1);
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    exp_data.push_back(mem_entry(32'h0));
    exp_data.push_back(mem_entry(32'h4));
    req_i = 1'b1; fetch_ready_i = 1'b1; rsp_en = 1'b1; gnt_budget = 2;
    wait_drain(20, "rw_pre_drain");
    check("rw_pre_req", instr_req_o, 1);
    check("rw_pre_addr", instr_addr_o, 32'h8);
    exp_addr.push_back(32'h8); exp_addr.push_back(32'h200);
    exp_data.push_back(mem_entry(32'h200));
    branch_i = 1'b1; branch_addr_i = 32'h200;
    tick(1);
    branch_i = 1'b0;
    tick(2);
    check("rw_hold_req", instr_req_o, 1);
    check("rw_hold_addr", instr_addr_o, 32'h8);
    check("rw_busy", busy_o, 1);
    gnt_budget = 2;
    wait_drain(20, "rw_drain");

    // Simultaneous branch and hardware-loop jump: branch wins
    do_reset(1'b1);
    branch_i = 1'b1; branch_addr_i = 32'h40;
    hwlp_jump_i = 1'b1; hwlp_target_i = 32'h80;
    tick(1);
    branch_i = 1'b0; hwlp_jump_i = 1'b0;
    exp_addr.push_back(32'h40);
    exp_data.push_back(mem_entry(32'h40));
    req_i = 1'b1; fetch_ready_i = 1'b1; rsp_en = 1'b1; gnt_budget = 1;
    wait_drain(20, "prio_drain");

    // Hardware-loop jump alone, unaligned target
    do_reset(1'b1);
    hwlp_jump_i = 1'b1; hwlp_target_i = 32'h86;
    tick(1);
    hwlp_jump_i = 1'b0;
    exp_addr.push_back(32'h84);
    exp_data.push_back(mem_entry(32'h84));
    req_i = 1'b1; fetch_ready_i = 1'b1; rsp_en = 1'b1; gnt_budget = 1;
    wait_drain(20, "hwlp_drain");

    // Bus error tagged on one entry only
    do_reset(1'b1);
    err_addr = 32'h4;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    exp_data.push_back(mem_entry(32'h0));
    exp_data.push_back(mem_entry(32'h4));
    exp_data.push_back(mem_entry(32'h8));
    req_i = 1'b1; fetch_ready_i = 1'b1; rsp_en = 1'b1; gnt_budget = 3;
    wait_drain(30, "err_drain");
    check("err_cleared", fetch_err_o, 0);

    // Reset mid-fetch, then stale responses after release
    rsp_en = 1'b0;
    exp_addr.push_back(32'hC); exp_addr.push_back(32'h10);
    gnt_budget = 2;
    tick(5);
    check("mid_busy", busy_o, 1);
    rst = 1'b1;
    req_i = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_en = 1'b1;
    tick(5);
    check("stale_consumed", 64'(bus_q.size()), 0);
    check("stale_ignored", fetch_valid_o, 0);
    check("stale_busy", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
